// File: rtl/gpio_bridge_pkg.sv
// ----------------------------------------------------------------------------
// gpio_bridge_pkg
// Shared definitions for the AHB-Lite to GPIO-core bridge:
//   - FSM state type (ERR1/ERR2 exist only when GPIO_BRIDGE_ERR_EN is defined)
//   - HTRANS / HSIZE encodings
//   - GPIO core word offsets and the default number of mapped registers
// ----------------------------------------------------------------------------
package gpio_bridge_pkg;

    localparam int NUM_REGS_DEF = 6;

    // AHB transfer types
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Only word transfers are supported
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // GPIO core word offsets
    localparam logic [2:0] GPIO_OFS_CNT  = 3'd0;
    localparam logic [2:0] GPIO_OFS_OUT1 = 3'd1;
    localparam logic [2:0] GPIO_OFS_OUT2 = 3'd2;
    localparam logic [2:0] GPIO_OFS_OUT3 = 3'd3;
    localparam logic [2:0] GPIO_OFS_OUT4 = 3'd4;
    localparam logic [2:0] GPIO_OFS_EN   = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_REQ  = 3'd2,
        RD_CAP  = 3'd3,
        RD_DONE = 3'd4
`ifdef GPIO_BRIDGE_ERR_EN
        ,
        ERR1    = 3'd5,
        ERR2    = 3'd6
`endif
    } state_e;

endpackage

// File: rtl/gpio_bridge_addr_chk.sv
// ----------------------------------------------------------------------------
// gpio_bridge_addr_chk
// Combinational legality check for an AHB address phase.
// Ports:
//   offset  in  3  word offset (haddr[4:2])
//   hsize   in  3  transfer size
//   legal   out 1  1 when offset < NUM_REGS and the transfer is a word
// ----------------------------------------------------------------------------
module gpio_bridge_addr_chk
    import gpio_bridge_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic [2:0] offset,
    input  logic [2:0] hsize,
    output logic       legal
);

    assign legal = (32'(offset) < 32'(NUM_REGS)) && (hsize == HSIZE_WORD);

endmodule

// File: rtl/gpio_ahb_bridge.sv
// ----------------------------------------------------------------------------
// gpio_ahb_bridge
// AHB-Lite slave that converts bus transfers into single-cycle GPIO core
// strobes. Writes complete with zero wait states; reads take two wait states
// (request, capture, done) and return registered data.
//
// Build option: GPIO_BRIDGE_ERR_EN
//   defined   : illegal transfers get the two-cycle AHB ERROR response
//   undefined : illegal writes are dropped, illegal reads return 0, both OKAY
//
// Ports:
//   clk, rstn                      clock, async active-low reset
//   hsel, haddr, htrans, hwrite,   AHB-Lite address phase
//   hsize, hready
//   hwdata                         AHB write data (data phase)
//   hreadyout, hresp, hrdata       AHB slave response
//   core_sel, core_wen, core_ren   GPIO core strobes
//   core_addr                      captured word offset, zero-extended
//   core_wdata, core_rdata         GPIO core data
// ----------------------------------------------------------------------------
module gpio_ahb_bridge
    import gpio_bridge_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              hsel,
    input  logic [31:0]       haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic              hready,
    input  logic [DATA_W-1:0] hwdata,
    output logic              hreadyout,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata,
    output logic              core_sel,
    output logic              core_wen,
    output logic              core_ren,
    output logic [31:0]       core_addr,
    output logic [DATA_W-1:0] core_wdata,
    input  logic [DATA_W-1:0] core_rdata
);

    state_e            state_q, state_d;
    logic [2:0]        ofs_q, ofs_d;
    logic [DATA_W-1:0] hrdata_q, hrdata_d;
    logic              legal;
    logic              can_accept;
    logic              accept;

    // Address bits outside the word offset and htrans[0] carry no meaning here.
    logic unused_bus;
    assign unused_bus = ^{haddr[31:5], haddr[1:0], htrans[0]};

    gpio_bridge_addr_chk #(
        .NUM_REGS (NUM_REGS)
    ) u_addr_chk (
        .offset (haddr[4:2]),
        .hsize  (hsize),
        .legal  (legal)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d    = IDLE;
        ofs_d      = ofs_q;
        hrdata_d   = hrdata_q;
        can_accept = 1'b0;
        hreadyout  = 1'b1;
        hresp      = 1'b0;
        core_sel   = 1'b0;
        core_wen   = 1'b0;
        core_ren   = 1'b0;
        core_wdata = '0;

        unique case (state_q)
            IDLE: begin
                can_accept = 1'b1;
            end
            WR: begin
                // One strobe per transfer: offset 0 is a counter that
                // advances on every write strobe.
                core_sel   = 1'b1;
                core_wen   = 1'b1;
                core_wdata = hwdata;
                can_accept = 1'b1;
            end
            RD_REQ: begin
                core_sel  = 1'b1;
                core_ren  = 1'b1;
                hreadyout = 1'b0;
                state_d   = RD_CAP;
            end
            RD_CAP: begin
                hreadyout = 1'b0;
                hrdata_d  = core_rdata;
                state_d   = RD_DONE;
            end
            RD_DONE: begin
                can_accept = 1'b1;
            end
`ifdef GPIO_BRIDGE_ERR_EN
            ERR1: begin
                hresp     = 1'b1;
                hreadyout = 1'b0;
                state_d   = ERR2;
            end
            ERR2: begin
                hresp      = 1'b1;
                can_accept = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // Address phase is only taken while the previous data phase is ending
        // (hreadyout=1), which makes WR/RD_DONE/ERR2 pipelined.
        accept = can_accept & hsel & hready & htrans[1];

        if (accept) begin
            ofs_d = haddr[4:2];
            if (legal) begin
                state_d = hwrite ? WR : RD_REQ;
            end else begin
`ifdef GPIO_BRIDGE_ERR_EN
                state_d = ERR1;
`else
                // Dropped write / zero read, completed in the next cycle
                // with OKAY and no core access.
                state_d = IDLE;
                if (!hwrite) begin
                    hrdata_d = '0;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            ofs_q    <= '0;
            hrdata_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q  <= state_d;
            ofs_q    <= ofs_d;
            hrdata_q <= hrdata_d;
        end
    end

    assign hrdata    = hrdata_q;
    assign core_addr = {29'd0, ofs_q};

endmodule

// File: tb/tb_gpio_ahb_bridge.sv
module tb_gpio_ahb_bridge;
    import gpio_bridge_pkg::*;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 6;

    logic              clk = 1'b0;
    logic              rstn;
    logic              hsel;
    logic [31:0]       haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic              hready;
    logic [DATA_W-1:0] hwdata;
    logic              hreadyout;
    logic              hresp;
    logic [DATA_W-1:0] hrdata;
    logic              core_sel;
    logic              core_wen;
    logic              core_ren;
    logic [31:0]       core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;

    // Single-slave system: bus ready follows the slave, unless forced low.
    logic hready_block = 1'b0;
    assign hready = hready_block ? 1'b0 : hreadyout;

    // Simple GPIO core stand-in: register file, optional forced read value.
    logic [31:0] core_mem [0:7];
    logic        force_en  = 1'b0;
    logic [31:0] force_val = '0;
    assign core_rdata = force_en ? force_val : core_mem[core_addr[2:0]];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 8; i++) core_mem[i] <= '0;
        end else if (core_sel && core_wen) begin
            core_mem[core_addr[2:0]] <= core_wdata;
        end
    end

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    always #5 clk = ~clk;

    gpio_ahb_bridge #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .hsel       (hsel),
        .haddr      (haddr),
        .htrans     (htrans),
        .hwrite     (hwrite),
        .hsize      (hsize),
        .hready     (hready),
        .hwdata     (hwdata),
        .hreadyout  (hreadyout),
        .hresp      (hresp),
        .hrdata     (hrdata),
        .core_sel   (core_sel),
        .core_wen   (core_wen),
        .core_ren   (core_ren),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata)
    );

    // ------------------------------------------------------------------
    // Reference model state and transfer list
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        hsel;
        logic [1:0]  trans;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    xfer_t       xq[$];
    int          wen_cyc[$];
    logic [31:0] ref_mem [0:7];
    logic [31:0] last_rd;
    int          checks   = 0;
    int          failures = 0;

    function automatic xfer_t mk(input logic wr, input logic [31:0] addr,
                                 input logic [2:0] size, input logic [31:0] wdata);
        xfer_t x;
        x.hsel  = 1'b1;
        x.trans = HTRANS_NONSEQ;
        x.wr    = wr;
        x.addr  = addr;
        x.size  = size;
        x.wdata = wdata;
        return x;
    endfunction

    function automatic xfer_t mk_idle(input int kind);
        xfer_t x;
        x       = mk(1'b1, 32'h0, HSIZE_WORD, 32'h0);
        x.hsel  = (kind != 0);
        x.trans = (kind == 0) ? HTRANS_NONSEQ : (kind == 1) ? HTRANS_IDLE : HTRANS_BUSY;
        return x;
    endfunction

    task automatic drive_idle();
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        haddr  = $urandom();
        hsize  = HSIZE_WORD;
        hwdata = $urandom();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) ref_mem[i] = '0;
        last_rd = '0;
    endtask

    // Drives the queued transfers as an AHB master (pipelined, honouring
    // hready) and scores each completed data phase against the model.
    // Entered and left at posedge+1.
    task automatic run_queue(input string tag);
        int          ai = 0;
        int          di = -1;
        int          budget = 0;
        int          waits = 0, resp_cyc = 0, wen_n = 0, ren_n = 0;
        bit          addr_bad = 0;
        logic [31:0] s_wdata = '0;
        logic        rdy;
        xfer_t       x;
        logic [2:0]  off;
        bit          legal;
        int          e_waits, e_resp_cyc, e_wen, e_ren;
        logic        e_resp;
        bit          e_chk_rd;
        logic [31:0] e_rdata;

        while ((ai < xq.size() || di >= 0) && budget < 4000) begin
            budget++;
            if (ai < xq.size()) begin
                hsel   = xq[ai].hsel;
                htrans = xq[ai].trans;
                hwrite = xq[ai].wr;
                haddr  = xq[ai].addr;
                hsize  = xq[ai].size;
            end else begin
                drive_idle();
            end
            hwdata = (di >= 0 && xq[di].wr) ? xq[di].wdata : $urandom();
            @(negedge clk);
            rdy = hreadyout;

            checks++;
            if (core_sel !== (core_wen | core_ren) || (core_wen & core_ren) !== 1'b0 ||
                (!core_sel && core_wdata !== '0)) begin
                failures++;
                $display("FAIL %s strobe_consistency: sel=%b wen=%b ren=%b wdata=%h required sel=wen|ren, wdata=0 when idle",
                         tag, core_sel, core_wen, core_ren, core_wdata);
            end

            if (di < 0) begin
                checks++;
                if (core_sel !== 1'b0 || hresp !== 1'b0 || hreadyout !== 1'b1) begin
                    failures++;
                    $display("FAIL %s no_data_phase: sel=%b hresp=%b hreadyout=%b required 0 0 1",
                             tag, core_sel, hresp, hreadyout);
                end
            end else begin
                if (core_wen === 1'b1) begin
                    wen_n++;
                    s_wdata = core_wdata;
                    wen_cyc.push_back(cycle);
                end
                if (core_ren === 1'b1) ren_n++;
                if (core_addr !== {29'd0, xq[di].addr[4:2]}) addr_bad = 1;
                if (hresp === 1'b1) resp_cyc++;
                if (hreadyout !== 1'b1) begin
                    waits++;
                end else begin
                    x     = xq[di];
                    off   = x.addr[4:2];
                    legal = (int'(off) < NUM_REGS) && (x.size == HSIZE_WORD);
                    e_rdata  = last_rd;
                    e_chk_rd = 1;
                    if (legal) begin
                        e_waits = x.wr ? 0 : 2;
                        e_resp_cyc = 0; e_resp = 1'b0;
                        e_wen = x.wr ? 1 : 0;
                        e_ren = x.wr ? 0 : 1;
                        if (!x.wr) e_rdata = force_en ? force_val : ref_mem[off];
                    end else begin
`ifdef GPIO_BRIDGE_ERR_EN
                        e_waits = 1; e_resp_cyc = 2; e_resp = 1'b1;
                        e_wen = 0; e_ren = 0; e_chk_rd = 0;
`else
                        e_waits = 0; e_resp_cyc = 0; e_resp = 1'b0;
                        e_wen = 0; e_ren = 0;
                        if (!x.wr) e_rdata = '0;
`endif
                    end

                    checks++;
                    if (waits != e_waits || resp_cyc != e_resp_cyc || hresp !== e_resp) begin
                        failures++;
                        $display("FAIL %s xfer%0d response: waits=%0d hresp_cycles=%0d hresp=%b required %0d %0d %b",
                                 tag, di, waits, resp_cyc, hresp, e_waits, e_resp_cyc, e_resp);
                    end
                    checks++;
                    if (wen_n != e_wen || ren_n != e_ren) begin
                        failures++;
                        $display("FAIL %s xfer%0d strobes: wen=%0d ren=%0d required %0d %0d",
                                 tag, di, wen_n, ren_n, e_wen, e_ren);
                    end
                    checks++;
                    if (addr_bad) begin
                        failures++;
                        $display("FAIL %s xfer%0d core_addr: not held at offset %0d during data phase",
                                 tag, di, off);
                    end
                    if (e_wen == 1) begin
                        checks++;
                        if (s_wdata !== x.wdata) begin
                            failures++;
                            $display("FAIL %s xfer%0d core_wdata: got %h required %h",
                                     tag, di, s_wdata, x.wdata);
                        end
                    end
                    if (e_chk_rd) begin
                        checks++;
                        if (hrdata !== e_rdata) begin
                            failures++;
                            $display("FAIL %s xfer%0d hrdata: got %h required %h",
                                     tag, di, hrdata, e_rdata);
                        end
                        if (!x.wr) last_rd = e_rdata;
                    end
                    if (legal && x.wr) ref_mem[off] = x.wdata;
                end
            end

            @(posedge clk);
            #1;
            if (rdy) begin
                if (di >= 0) di = -1;
                if (ai < xq.size()) begin
                    if (xq[ai].hsel && xq[ai].trans[1]) begin
                        di = ai;
                        waits = 0; resp_cyc = 0; wen_n = 0; ren_n = 0;
                        addr_bad = 0; s_wdata = '0;
                    end
                    ai++;
                end
            end
        end
        checks++;
        if (budget >= 4000) begin
            failures++;
            $display("FAIL %s timeout: transfers incomplete after %0d cycles", tag, budget);
        end
        xq.delete();
        drive_idle();
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rstn   = 1'b0;
        hsel   = 1'b1;
        htrans = HTRANS_NONSEQ;
        hwrite = 1'b1;
        haddr  = 32'h4;
        hsize  = HSIZE_WORD;
        hwdata = 32'hFFFF_FFFF;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (hreadyout !== 1'b1 || hresp !== 1'b0 || hrdata !== '0 ||
                core_sel !== 1'b0 || core_wen !== 1'b0 || core_ren !== 1'b0 ||
                core_addr !== '0 || core_wdata !== '0) begin
                failures++;
                $display("FAIL reset_values: hreadyout=%b hresp=%b hrdata=%h sel=%b wen=%b ren=%b addr=%h wdata=%h required 1 0 0 0 0 0 0 0",
                         hreadyout, hresp, hrdata, core_sel, core_wen, core_ren, core_addr, core_wdata);
            end
        end
        rstn = 1'b1;
        drive_idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_basic();
        wen_cyc.delete();
        xq.push_back(mk(1'b1, {27'd0, GPIO_OFS_OUT1, 2'b00}, HSIZE_WORD, 32'hFFFF_FFFF));
        run_queue("write_basic");
        checks++;
        if (wen_cyc.size() != 1) begin
            failures++;
            $display("FAIL write_basic pulse_count: got %0d required 1", wen_cyc.size());
        end
    endtask

    task automatic test_read_basic();
        force_en  = 1'b1;
        force_val = 32'hA5A5_0F0F;
        xq.push_back(mk(1'b0, {27'd0, GPIO_OFS_OUT2, 2'b00}, HSIZE_WORD, 32'h0));
        run_queue("read_basic");
        force_en = 1'b0;
        @(negedge clk);
        checks++;
        if (hrdata !== 32'hA5A5_0F0F) begin
            failures++;
            $display("FAIL read_basic hold: hrdata=%h required a5a50f0f", hrdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        wen_cyc.delete();
        repeat (3) xq.push_back(mk(1'b1, {27'd0, GPIO_OFS_CNT, 2'b00}, HSIZE_WORD, $urandom()));
        run_queue("back_to_back");
        checks++;
        if (wen_cyc.size() != 3) begin
            failures++;
            $display("FAIL back_to_back pulse_count: got %0d required 3", wen_cyc.size());
        end else begin
            checks++;
            if (wen_cyc[1] != wen_cyc[0] + 1 || wen_cyc[2] != wen_cyc[1] + 1) begin
                failures++;
                $display("FAIL back_to_back spacing: cycles %0d %0d %0d required consecutive",
                         wen_cyc[0], wen_cyc[1], wen_cyc[2]);
            end
        end
    endtask

    task automatic test_illegal();
        wen_cyc.delete();
        xq.push_back(mk(1'b1, 32'h0000_0018, HSIZE_WORD, 32'h1111_2222));
        xq.push_back(mk(1'b0, 32'h0000_0018, HSIZE_WORD, 32'h0));
        xq.push_back(mk(1'b1, 32'h0000_0004, 3'b001, 32'h3333_4444));
        xq.push_back(mk(1'b0, 32'h0000_001C, HSIZE_WORD, 32'h0));
        run_queue("illegal");
        checks++;
        if (wen_cyc.size() != 0) begin
            failures++;
            $display("FAIL illegal no_write: got %0d pulses required 0", wen_cyc.size());
        end
        // Offset 1 must still hold the value written before the dropped write.
        xq.push_back(mk(1'b0, 32'h0000_0004, HSIZE_WORD, 32'h0));
        run_queue("illegal_readback");
    endtask

    task automatic test_idle_busy();
        for (int mode = 0; mode < 3; mode++) begin
            hready_block = (mode == 0);
            hsel   = (mode != 2);
            htrans = (mode == 1) ? HTRANS_BUSY : HTRANS_NONSEQ;
            hwrite = 1'b1;
            haddr  = {27'd0, GPIO_OFS_EN, 2'b00};
            hsize  = HSIZE_WORD;
            repeat (3) begin
                hwdata = $urandom();
                @(negedge clk);
                checks++;
                if (core_sel !== 1'b0 || hreadyout !== 1'b1 || hresp !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_busy mode%0d: sel=%b hreadyout=%b hresp=%b required 0 1 0",
                             mode, core_sel, hreadyout, hresp);
                end
                @(posedge clk);
                #1;
            end
        end
        hready_block = 1'b0;
        drive_idle();
        // A following read must see a fresh IDLE state and nothing written.
        xq.push_back(mk(1'b0, {27'd0, GPIO_OFS_EN, 2'b00}, HSIZE_WORD, 32'h0));
        run_queue("idle_busy_after");
    endtask

    task automatic test_reset_mid_read();
        force_en  = 1'b1;
        force_val = 32'h1234_5678;
        xq.push_back(mk(1'b0, {27'd0, GPIO_OFS_OUT3, 2'b00}, HSIZE_WORD, 32'h0));
        run_queue("pre_reset_read");

        hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b0;
        haddr = {27'd0, GPIO_OFS_OUT3, 2'b00}; hsize = HSIZE_WORD;
        @(posedge clk);
        #1;
        drive_idle();
        @(negedge clk);
        checks++;
        if (core_ren !== 1'b1 || hreadyout !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_read req: ren=%b hreadyout=%b required 1 0", core_ren, hreadyout);
        end
        @(posedge clk);
        #1;
        force_val = 32'hDEAD_BEEF;
        checks++;
        if (hreadyout !== 1'b0 || core_ren !== 1'b0 || hrdata !== 32'h1234_5678) begin
            failures++;
            $display("FAIL reset_mid_read cap: hreadyout=%b ren=%b hrdata=%h required 0 0 12345678",
                     hreadyout, core_ren, hrdata);
        end
        rstn = 1'b0;
        model_reset();
        #1;
        checks++;
        if (hreadyout !== 1'b1 || hresp !== 1'b0 || hrdata !== '0 || core_sel !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_read abort: hreadyout=%b hresp=%b hrdata=%h sel=%b required 1 0 0 0",
                     hreadyout, hresp, hrdata, core_sel);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            checks++;
            if (core_sel !== 1'b0 || hrdata !== '0 || hreadyout !== 1'b1) begin
                failures++;
                $display("FAIL reset_mid_read after: sel=%b hrdata=%h hreadyout=%b required 0 0 1",
                         core_sel, hrdata, hreadyout);
            end
        end
        force_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int burst = 0; burst < 3; burst++) begin
            for (int n = 0; n < 40; n++) begin
                logic [31:0] a;
                logic [2:0]  sz;
                logic [2:0]  off;
                if ($urandom_range(0, 9) == 0) begin
                    xq.push_back(mk_idle(int'($urandom_range(0, 2))));
                end else begin
                    off = 3'($urandom_range(0, 7));
                    a   = $urandom();
                    a[4:0] = {off, 2'b00};
                    sz  = HSIZE_WORD;
                    if ($urandom_range(0, 9) == 0) begin
                        sz = 3'($urandom_range(0, 7));
                        if (sz == HSIZE_WORD) sz = 3'b001;
                    end
                    xq.push_back(mk(1'($urandom_range(0, 1)), a, sz, $urandom()));
                    if ($urandom_range(0, 1) == 1) xq[xq.size()-1].trans = HTRANS_SEQ;
                end
            end
            run_queue($sformatf("random%0d", burst));
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_back_to_back();
        test_illegal();
        test_idle_busy();
        test_reset_mid_read();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
